// File: rtl/adc_sample_sequencer.sv
// Frame sequencer for a 12-bit, 16-clock serial ADC: timer or start pulse launches
// a chip-select/SCLK frame, the result is shifted in MSB first and strobed out.
module adc_sample_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int SAMPLE_DIV = 500000
) (
    input  logic        clk_in,
    input  logic        clk_rst,
    input  logic        enable,
    input  logic        start,
    input  logic        adc_sdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          hi, hi_nxt;
    logic [11:0]   shreg, shreg_nxt;
    logic [TW-1:0] timer;
    logic          tick, trigger, cnt_last, in_frame;

    assign tick     = enable && (timer == TW'(SAMPLE_DIV - 1));
    assign trigger  = enable && (tick || start);
    assign cnt_last = (cnt == CW'(CLK_DIV - 1));
    assign in_frame = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    always_ff @(posedge clk_in or negedge clk_rst) begin
        if (!clk_rst) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge clk_rst) begin
        if (!clk_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            hi      <= 1'b0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            hi      <= hi_nxt;
            shreg   <= shreg_nxt;
        end
    end

    // cnt times each CLK_DIV-long phase; hi marks the high half of an SCLK period.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        hi_nxt      = hi;
        shreg_nxt   = shreg;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_nxt   = SHIFT;
                    cnt_nxt     = '0;
                    hi_nxt      = 1'b0;
                    bit_cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_last) begin
                    cnt_nxt = '0;
                    if (!hi) begin
                        // Only the last 12 bits survive; the 4 leading bits fall off the top.
                        hi_nxt    = 1'b1;
                        shreg_nxt = {shreg[10:0], adc_sdata};
                    end else if (bit_cnt == 4'd15) begin
                        state_nxt = HOLD;
                    end else begin
                        hi_nxt      = 1'b0;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs decode the next state so pins change on the same edge as the state.
    always_ff @(posedge clk_in or negedge clk_rst) begin
        if (!clk_rst) begin
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            adc_cs_n     <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
            adc_sclk     <= !((state_nxt == SHIFT) && !hi_nxt);
            busy         <= (state_nxt == SETUP) || (state_nxt == SHIFT) || (state_nxt == HOLD);
            sample_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                sample <= shreg_nxt;
            end
            if (!enable) begin
                overrun <= 1'b0;
            end else if (trigger && in_frame) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed and randomized bench for adc_sample_sequencer; outputs are predicted
// cycle by cycle from frame-offset arithmetic and an ADC pin model.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

    localparam int CD = 2;
    localparam int SD = 200;
    localparam int FR = 34 * CD;

    logic        clk_in = 1'b0;
    logic        clk_rst = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        adc_sdata = 1'b0;
    logic        adc_cs_n, adc_sclk, sample_valid, busy, overrun;
    logic [11:0] sample;

    adc_sample_sequencer #(.CLK_DIV(CD), .SAMPLE_DIV(SD)) dut (
        .clk_in(clk_in), .clk_rst(clk_rst), .enable(enable), .start(start),
        .adc_sdata(adc_sdata), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .sample(sample), .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk_in = ~clk_in;

    // ADC pins: new word on CS fall, next bit (MSB first) after each SCLK fall.
    logic [15:0] adc_word = 16'h0;
    logic [15:0] fixed_word = 16'h0A5C;
    logic        fixed_en = 1'b0;
    int          adc_bit = 0;
    logic        cs_q = 1'b1, sclk_q = 1'b1;
    always @(adc_cs_n or adc_sclk) begin
        if (cs_q === 1'b1 && adc_cs_n === 1'b0) begin
            adc_word = fixed_en ? fixed_word : 16'($urandom);
            adc_bit  = 0;
        end else if (adc_cs_n === 1'b0 && sclk_q === 1'b1 && adc_sclk === 1'b0 && adc_bit < 16) begin
            adc_sdata = adc_word[4'(15 - adc_bit)];
            adc_bit++;
        end
        cs_q   = adc_cs_n;
        sclk_q = adc_sclk;
    end

    int          n_chk = 0, n_err = 0;
    int          cyc = 0, m_T = 0, m_tmr = 0;
    bit          m_act = 0, m_ovr = 0;
    logic [11:0] m_sample = 12'h0;
    logic        e_cs, e_sclk, e_busy, e_valid;
    int          n_falls = 0, n_valid = 0, last_valid = -1;
    logic        prev_sclk = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc + 1, obs, exp);
        end
    endtask

    // Expected outputs for cycle cyc+1, from its offset within the current frame.
    task automatic calc_exp();
        int k;
        bit act;
        k   = cyc - m_T;
        act = m_act && (k >= 0) && (k <= FR);
        e_cs    = !(act && k < 33 * CD);
        e_busy  = act && k < FR;
        e_valid = act && k == FR;
        e_sclk  = 1'b1;
        if (act && k >= CD && k < 33 * CD) e_sclk = (((k - CD) / CD) % 2) == 1;
    endtask

    task automatic model_edge();
        int kc;
        bit busy_c, idle_c, tk;
        cyc++;
        if (!clk_rst) begin
            m_act = 0; m_ovr = 0; m_tmr = 0; m_sample = 12'h0;
        end else begin
            kc     = cyc - m_T - 1;
            busy_c = m_act && kc >= 0 && kc < FR;
            idle_c = !m_act || kc > FR;
            tk     = enable && (m_tmr == SD - 1);
            if (!enable) begin
                m_act = 0; m_ovr = 0;
            end else if (start || tk) begin
                if (idle_c) begin m_act = 1; m_T = cyc; end
                else if (busy_c) m_ovr = 1;
            end
            m_tmr = (!enable || m_tmr == SD - 1) ? 0 : m_tmr + 1;
        end
        calc_exp();
        if (e_valid) m_sample = adc_word[11:0];
    endtask

    task automatic check_outputs();
        chk("adc_cs_n", adc_cs_n, e_cs);
        chk("adc_sclk", adc_sclk, e_sclk);
        chk("busy", busy, e_busy);
        chk("sample_valid", sample_valid, e_valid);
        chk("overrun", overrun, m_ovr);
        chk("sample", sample, m_sample);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_outputs();
        if (prev_sclk === 1'b1 && adc_sclk === 1'b0) n_falls++;
        prev_sclk = adc_sclk;
        if (sample_valid === 1'b1) begin n_valid++; last_valid = cyc + 1; end
    endtask

    initial begin
        int T, E, prev;
        logic [11:0] kept;
        repeat (3) step();
        clk_rst = 1'b1;
        step();

        // Fixed-word frame from a start pulse in the first enabled cycle.
        fixed_en = 1'b1;
        enable = 1'b1; start = 1'b1; step(); start = 1'b0;
        T = cyc; E = cyc; n_falls = 0; n_valid = 0;
        repeat (70) step();
        chk("sclk_falls", n_falls, 16);
        chk("fixed_valid_count", n_valid, 1);
        chk("fixed_valid_cycle", last_valid, T + 69);
        chk("fixed_sample", sample, 12'hA5C);
        fixed_en = 1'b0;

        // Timer-driven frames while enable stays high.
        prev = -1; n_valid = 0;
        while (cyc < E + 1000) begin
            step();
            if (sample_valid === 1'b1) begin
                if (prev >= 0) chk("valid_spacing", cyc + 1 - prev, SD);
                else chk("first_tick_valid", cyc + 1, E + SD + FR);
                prev = cyc + 1;
            end
        end
        chk("tick_frames", n_valid, 4);
        chk("timer_no_overrun", overrun, 0);

        // Second start inside a frame: dropped, overrun sticky until enable drops.
        enable = 1'b0; step();
        enable = 1'b1; start = 1'b1; step(); start = 1'b0;
        T = cyc;
        repeat (9) step();
        start = 1'b1; step(); start = 1'b0;
        chk("overrun_set", overrun, 1);
        n_valid = 0;
        repeat (70) step();
        chk("double_start_frames", n_valid, 1);
        chk("overrun_held", overrun, 1);
        enable = 1'b0; step();
        chk("overrun_clear", overrun, 0);

        // Start coincident with the first timer tick.
        enable = 1'b1; step(); E = cyc;
        repeat (198) step();
        n_valid = 0;
        start = 1'b1; step(); start = 1'b0;
        repeat (75) step();
        chk("coincident_frames", n_valid, 1);
        chk("coincident_overrun", overrun, 0);

        // Enable dropped 30 cycles into a frame.
        enable = 1'b0; step();
        enable = 1'b1; start = 1'b1; step(); start = 1'b0;
        T = cyc;
        repeat (29) step();
        kept = m_sample;
        enable = 1'b0; n_valid = 0; step();
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sclk", adc_sclk, 1);
        repeat (50) step();
        chk("abort_no_valid", n_valid, 0);
        chk("abort_sample_kept", sample, kept);
        enable = 1'b1; start = 1'b1; step(); start = 1'b0;
        T = cyc; n_valid = 0;
        repeat (70) step();
        chk("restart_valid_count", n_valid, 1);
        chk("restart_valid_cycle", last_valid, T + 69);

        // Asynchronous reset during SHIFT.
        enable = 1'b0; step();
        enable = 1'b1; start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        clk_rst = 1'b0;
        #1;
        m_act = 0; m_ovr = 0; m_tmr = 0; m_sample = 12'h0;
        calc_exp();
        check_outputs();
        repeat (3) step();
        clk_rst = 1'b1; n_valid = 0;
        repeat (80) step();
        chk("post_reset_no_valid", n_valid, 0);

        // Random enable/start traffic.
        repeat (3000) begin
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            start = ($urandom_range(0, 59) == 0);
            step();
        end
        start = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
